// File: rtl/pwm_multi_pkg.sv
// Shared register map for the pwm_multi peripheral.
// Holds the register indices and the CTRL bit positions.
package pwm_multi_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_PERIOD = 1;
  localparam int REG_PRESC  = 2;
  localparam int REG_POL    = 3;
  localparam int REG_DUTY0  = 4;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_OVF_BIT = 1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: a double-buffered duty register, compare, polarity and output flop.
// The active duty follows the shadow continuously while disabled and only at a boundary while enabled.
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt,
  input  logic             bnd,
  input  logic             en,
  input  logic             pol,
  input  logic             wr,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] duty,
  output logic             out
);

  logic [WIDTH-1:0] duty_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
    end else if (wr) begin
      duty <= di;
    end
  end

  // A write on a boundary cycle is deferred: the active copy samples the pre-write shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_act <= '0;
    end else if (!en || bnd) begin
      duty_act <= duty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= 1'b0;
    end else begin
      out <= en ? ((cnt < duty_act) ^ pol) : pol;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: bus decode, shared prescaler and period counter, CTRL/OVF and read mux.
// The read-data port is named dout because "do" is a reserved word in SystemVerilog.
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int PRESC_WIDTH = 8,
  localparam int ADDR_W     = $clog2(CHANNELS + 4)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cs,
  input  logic                wren,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WIDTH-1:0]    di,
  output logic [WIDTH-1:0]    dout,
  output logic [CHANNELS-1:0] out
);

  logic                   en;
  logic                   ovf;
  logic [WIDTH-1:0]       period_sh;
  logic [WIDTH-1:0]       top_act;
  logic [PRESC_WIDTH-1:0] presc_sh;
  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic [WIDTH-1:0]       cnt;
  logic [CHANNELS-1:0]    pol;
  logic [WIDTH-1:0]       duty_sh [CHANNELS];

  logic wr;
  logic wr_ctrl;
  logic wr_period;
  logic wr_presc;
  logic wr_pol;
  logic tick;
  logic bnd;

  assign wr        = cs && wren;
  assign wr_ctrl   = wr && (addr == ADDR_W'(REG_CTRL));
  assign wr_period = wr && (addr == ADDR_W'(REG_PERIOD));
  assign wr_presc  = wr && (addr == ADDR_W'(REG_PRESC));
  assign wr_pol    = wr && (addr == ADDR_W'(REG_POL));

  assign tick = (presc_cnt == presc_sh);
  assign bnd  = en && tick && (cnt == top_act);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      en        <= 1'b0;
      period_sh <= '0;
      presc_sh  <= '0;
      pol       <= '0;
    end else begin
      if (wr_ctrl) begin
        en <= di[CTRL_EN_BIT];
      end
      if (wr_period) begin
        period_sh <= di;
      end
      if (wr_presc) begin
        presc_sh <= di[PRESC_WIDTH-1:0];
      end
      if (wr_pol) begin
        pol <= di[CHANNELS-1:0];
      end
    end
  end

  // A boundary setting OVF takes priority over a simultaneous write-1-clear.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ovf <= 1'b0;
    end else if (bnd) begin
      ovf <= 1'b1;
    end else if (wr_ctrl && di[CTRL_OVF_BIT]) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc_cnt <= '0;
    end else if (!en || wr_presc || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= (cnt == top_act) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      top_act <= '0;
    end else if (!en || bnd) begin
      top_act <= period_sh;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr_duty;

    assign wr_duty = wr && (addr == ADDR_W'(REG_DUTY0 + i));

    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk  (sys_clk),
      .rst  (sys_rst),
      .cnt  (cnt),
      .bnd  (bnd),
      .en   (en),
      .pol  (pol[i]),
      .wr   (wr_duty),
      .di   (di),
      .duty (duty_sh[i]),
      .out  (out[i])
    );
  end

  // Reads return shadow values; any index outside the map reads as zero.
  always_comb begin
    dout = '0;
    if (cs) begin
      if (addr == ADDR_W'(REG_CTRL)) begin
        dout[CTRL_EN_BIT]  = en;
        dout[CTRL_OVF_BIT] = ovf;
      end
      if (addr == ADDR_W'(REG_PERIOD)) begin
        dout = period_sh;
      end
      if (addr == ADDR_W'(REG_PRESC)) begin
        dout[PRESC_WIDTH-1:0] = presc_sh;
      end
      if (addr == ADDR_W'(REG_POL)) begin
        dout[CHANNELS-1:0] = pol;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (addr == ADDR_W'(REG_DUTY0 + i)) begin
          dout = duty_sh[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: the driver pushes the expected out/dout of each cycle,
// computed from a period-position reference model, and a negedge monitor pops and compares.
module tb_pwm_multi;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       cs;
  logic       wren;
  logic [2:0] addr;
  logic [7:0] di;
  logic [7:0] dout;
  logic [3:0] out;

  pwm_multi #(
    .WIDTH(8),
    .CHANNELS(4),
    .PRESC_WIDTH(8)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cs      (cs),
    .wren    (wren),
    .addr    (addr),
    .di      (di),
    .dout    (dout),
    .out     (out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0] out;
    logic [7:0] dout;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  // Reference model: position inside the current period plus shadow and latched values.
  bit         m_en;
  bit         m_ovf;
  int         m_top;
  int         m_presc;
  int         m_top_act;
  int         m_elapsed;
  logic [3:0] m_pol;
  logic [3:0] m_out;
  int         m_duty [4];
  int         m_duty_act [4];

  task automatic model_reset();
    m_en = 0; m_ovf = 0; m_top = 0; m_presc = 0; m_top_act = 0;
    m_elapsed = 0; m_pol = '0; m_out = '0;
    for (int i = 0; i < 4; i++) begin
      m_duty[i] = 0;
      m_duty_act[i] = 0;
    end
  endtask

  function automatic bit m_bnd();
    return m_en && (m_elapsed == (m_top_act + 1) * (m_presc + 1) - 1);
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {6'b0, m_ovf, m_en};
      3'd1:    return 8'(m_top);
      3'd2:    return 8'(m_presc);
      3'd3:    return {4'b0, m_pol};
      default: return 8'(m_duty[int'(a) - 4]);
    endcase
  endfunction

  task automatic model_step(input bit w, input logic [2:0] a, input logic [7:0] d);
    logic [3:0] nout;
    bit b;
    int pos;
    b = m_bnd();
    pos = m_elapsed / (m_presc + 1);
    for (int i = 0; i < 4; i++) begin
      nout[i] = m_en ? ((pos < m_duty_act[i]) ^ m_pol[i]) : m_pol[i];
    end
    if (!m_en || b) begin
      m_top_act = m_top;
      m_duty_act = m_duty;
      m_elapsed = 0;
    end else begin
      m_elapsed++;
    end
    if (b) m_ovf = 1;
    else if (w && a == 3'd0 && d[1]) m_ovf = 0;
    if (w) begin
      case (a)
        3'd0:    m_en = d[0];
        3'd1:    m_top = int'(d);
        3'd2:    m_presc = int'(d);
        3'd3:    m_pol = d[3:0];
        default: m_duty[int'(a) - 4] = int'(d);
      endcase
    end
    m_out = nout;
  endtask

  task automatic check_output(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s cyc=%0d got %0h expected %0h", name, c, act, exp);
  endtask

  task automatic apply_stimulus(input logic c, input logic w, input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    cs = c; wren = w; addr = a; di = d;
    e.out  = m_out;
    e.dout = c ? m_read(a) : 8'h00;
    e.cyc  = cyc;
    sb_q.push_back(e);
    @(posedge sys_clk);
    model_step(c && w, a, d);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic rd(input logic [2:0] a);
    apply_stimulus(1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    apply_stimulus(1'b1, 1'b1, a, d);
  endtask

  task automatic wait_bnd();
    int n = 0;
    while (!m_bnd() && n < 300) begin
      idle(1);
      n++;
    end
    if (!m_bnd()) check_output("bnd_timeout", cyc, 8'(n), 8'h00);
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output("out", e.cyc, {4'b0, out}, {4'b0, e.out});
      check_output("dout", e.cyc, dout, e.dout);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst = 1'b1; cs = 1'b0; wren = 1'b0; addr = '0; di = '0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check_output("reset_out", cyc, {4'b0, out}, 8'h00);
    sys_rst = 1'b0;

    // Disabled: every register reads zero, then POL drives the idle level.
    for (int a = 0; a < 8; a++) rd(3'(a));
    wr(3'd3, 8'h05);
    idle(3);

    // Single channel, PRESC=0: 3 high / 7 low over a 10-cycle period.
    wr(3'd3, 8'h00);
    wr(3'd1, 8'd9);
    wr(3'd2, 8'd0);
    wr(3'd4, 8'd3);
    wr(3'd0, 8'h01);
    idle(25);
    rd(3'd0);

    // Prescaled: TOP=3, PRESC=2, duty 0 and duty above TOP.
    wr(3'd0, 8'h00);
    wr(3'd1, 8'd3);
    wr(3'd2, 8'd2);
    wr(3'd5, 8'd0);
    wr(3'd6, 8'd5);
    wr(3'd0, 8'h01);
    idle(30);

    // Duty change mid-period, then a write landing exactly on the boundary.
    wr(3'd4, 8'd3);
    wait_bnd();
    idle(4);
    wr(3'd4, 8'd7);
    idle(20);
    wait_bnd();
    wr(3'd4, 8'd1);
    idle(28);

    // OVF write-1-clear, and a clear colliding with a boundary.
    wr(3'd0, 8'h03);
    rd(3'd0);
    wait_bnd();
    wr(3'd0, 8'h03);
    rd(3'd0);

    // Randomised traffic; PRESC is only rewritten while disabled.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40) idle(1);
      else if (r < 55) rd(3'($urandom_range(0, 7)));
      else if (r < 70) wr(3'(4 + $urandom_range(0, 3)), 8'($urandom_range(0, 17)));
      else if (r < 78) wr(3'd1, 8'($urandom_range(0, 15)));
      else if (r < 84) wr(3'd3, 8'($urandom_range(0, 15)));
      else if (r < 92) wr(3'd0, {6'b0, 1'($urandom_range(0, 1)), 1'b1});
      else begin
        wr(3'd0, 8'h00);
        wr(3'd2, 8'($urandom_range(0, 3)));
        idle(2);
        wr(3'd0, 8'h01);
      end
    end

    // Asynchronous reset mid-period with all channels at the inverted level.
    wr(3'd0, 8'h00);
    wr(3'd3, 8'h0F);
    for (int i = 0; i < 4; i++) wr(3'(4 + i), 8'd0);
    wr(3'd1, 8'd9);
    wr(3'd2, 8'd0);
    wr(3'd0, 8'h01);
    idle(4);
    #6;
    sys_rst = 1'b1;
    #1;
    check_output("async_rst_out", cyc, {4'b0, out}, 8'h00);
    repeat (2) @(posedge sys_clk);
    #1;
    check_output("held_rst_out", cyc, {4'b0, out}, 8'h00);
    sys_rst = 1'b0;
    model_reset();
    sb_q.delete();
    rd(3'd0);
    rd(3'd3);
    wr(3'd3, 8'h0A);
    idle(3);

    @(negedge sys_clk);
    #1;
    check_output("sb_drain", cyc, 8'(sb_q.size()), 8'h00);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
